alu_preprocess_pipe: RTL and testbench

//  Parametrised, registered successor of the ALU operand preprocessor. Decodes the 3-bit ALU op,

---
 rtl/alu_preprocess_pipe.sv | 171 +++++++++++++++++
 tb/tb_alu_preprocess_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_preprocess_pipe.sv
// Registered ALU operand preprocessor: op decode into a_mod/b_mod, valid/ready
// handshake through an output register plus one skid entry, saturating issue counter.
//
// state   | meaning
// S_EMPTY | output register empty, skid empty
// S_ONE   | output register holds a beat, skid empty
// S_TWO   | output register and skid both hold a beat (in_ready low)
module alu_preprocess_pipe #(
    parameter int WIDTH = 4,
    parameter bit CPL2  = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_mod,
    output logic [WIDTH-1:0] b_mod,
    output logic [2:0]       op_out,
    output logic             cin_out,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             drain;
    logic             ld_or_in;
    logic             ld_or_sk;
    logic             ld_sk;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;
    logic [WIDTH-1:0] sk_a;
    logic [WIDTH-1:0] sk_b;
    logic [2:0]       sk_op;
    logic             sk_cin;

    // Operand decode on the input side; negation either leaves the +1 to the core or folds it in.
    always_comb begin
        dec_a = a;
        dec_b = b;
        case (op)
            3'b001: begin
                dec_a = ONE;
                dec_b = a;
            end
            3'b010: begin
                if (CPL2) begin
                    dec_a = '0;
                    dec_b = ~a + ONE;
                end else begin
                    dec_a = ONE;
                    dec_b = ~a;
                end
            end
            3'b011: begin
                if (CPL2) begin
                    dec_a = '0;
                    dec_b = ~b + ONE;
                end else begin
                    dec_a = ONE;
                    dec_b = ~b;
                end
            end
            default: begin
                dec_a = a;
                dec_b = b;
            end
        endcase
    end

    assign accept = in_valid && (state != S_TWO);
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && !out_ready) begin
                    state_nxt = S_TWO;
                end else if (!accept && out_ready) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_ready && !accept) begin
                    state_nxt = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Flags come straight from the registered state, so in_ready has no path from the inputs.
    always_comb begin
        out_valid = (state != S_EMPTY);
        in_ready  = (state != S_TWO);
        ld_or_sk  = (state == S_TWO) && out_ready;
        ld_or_in  = accept && ((state == S_EMPTY) || ((state == S_ONE) && out_ready));
        ld_sk     = accept && !ld_or_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mod   <= '0;
            b_mod   <= '0;
            op_out  <= '0;
            cin_out <= 1'b0;
        end else if (ld_or_sk) begin
            a_mod   <= sk_a;
            b_mod   <= sk_b;
            op_out  <= sk_op;
            cin_out <= sk_cin;
        end else if (ld_or_in) begin
            a_mod   <= dec_a;
            b_mod   <= dec_b;
            op_out  <= op;
            cin_out <= cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_a   <= '0;
            sk_b   <= '0;
            sk_op  <= '0;
            sk_cin <= 1'b0;
        end else if (ld_sk) begin
            sk_a   <= dec_a;
            sk_b   <= dec_b;
            sk_op  <= op;
            sk_cin <= cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (drain && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_preprocess_pipe.sv
// Bench for alu_preprocess_pipe: three instances (CPL2=0, CPL2=1, CNT_W=2) share one stimulus
// stream and are checked against a queue-based reference of in-flight beats.
module tb_alu_preprocess_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       cin;
    logic       out_ready;

    logic       in_ready0, in_ready1, in_ready2;
    logic       out_valid0, out_valid1, out_valid2;
    logic [7:0] a_mod0, a_mod1, a_mod2;
    logic [7:0] b_mod0, b_mod1, b_mod2;
    logic [2:0] op_out0, op_out1, op_out2;
    logic       cin_out0, cin_out1, cin_out2;
    logic [7:0] op_count0, op_count1;
    logic [1:0] op_count2;

    always #5 clk = ~clk;

    alu_preprocess_pipe #(.WIDTH(8), .CPL2(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready),
        .a_mod(a_mod0), .b_mod(b_mod0), .op_out(op_out0), .cin_out(cin_out0), .op_count(op_count0)
    );
    alu_preprocess_pipe #(.WIDTH(8), .CPL2(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
        .a_mod(a_mod1), .b_mod(b_mod1), .op_out(op_out1), .cin_out(cin_out1), .op_count(op_count1)
    );
    alu_preprocess_pipe #(.WIDTH(8), .CPL2(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid2), .out_ready(out_ready),
        .a_mod(a_mod2), .b_mod(b_mod2), .op_out(op_out2), .cin_out(cin_out2), .op_count(op_count2)
    );

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] b0;
        logic [7:0] a1;
        logic [7:0] b1;
        logic [2:0] op;
        logic       cin;
    } beat_t;

    beat_t q[$];
    int    exp_cnt8;
    int    exp_cnt2;
    int    tests_run = 0;
    int    failures  = 0;

    // snapshot of one cycle, taken 1 ns after the falling edge
    int         s_occ;
    logic       s_ov0, s_ov1, s_ov2;
    logic       s_ir0, s_ir1, s_ir2;
    logic       s_macc, s_mxfer, s_has_exp;
    beat_t      s_exp;
    logic [7:0] o_a0, o_b0, o_a1, o_b1, o_a2, o_b2;
    logic [2:0] o_op0, o_op1;
    logic       o_cin0, o_cin1;
    int         s_cnt8, s_cnt2, e_cnt8, e_cnt2;

    function automatic beat_t ref_beat(input logic [7:0] ra, input logic [7:0] rb,
                                       input logic [2:0] rop, input logic rc);
        beat_t r;
        r.op  = rop;
        r.cin = rc;
        r.a0  = ra;
        r.b0  = rb;
        r.a1  = ra;
        r.b1  = rb;
        case (rop)
            3'd1: begin
                r.a0 = 8'd1; r.b0 = ra;
                r.a1 = 8'd1; r.b1 = ra;
            end
            3'd2: begin
                r.a0 = 8'd1; r.b0 = 8'(255 - int'(ra));
                r.a1 = 8'd0; r.b1 = 8'(256 - int'(ra));
            end
            3'd3: begin
                r.a0 = 8'd1; r.b0 = 8'(255 - int'(rb));
                r.a1 = 8'd0; r.b1 = 8'(256 - int'(rb));
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 8'h00; b = 8'h00; op = 3'd0; cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        exp_cnt8 = 0;
        exp_cnt2 = 0;
    endtask

    task automatic cycle(input logic v, input logic r, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] iop, input logic ic);
        @(negedge clk);
        in_valid = v; out_ready = r;
        a = ia; b = ib; op = iop; cin = ic;
        #1;
        s_occ     = q.size();
        s_has_exp = (q.size() > 0);
        if (s_has_exp) s_exp = q[0];
        s_mxfer = s_has_exp && r;
        s_macc  = v && (q.size() < 2);
        s_ov0 = out_valid0; s_ov1 = out_valid1; s_ov2 = out_valid2;
        s_ir0 = in_ready0;  s_ir1 = in_ready1;  s_ir2 = in_ready2;
        o_a0 = a_mod0; o_b0 = b_mod0; o_op0 = op_out0; o_cin0 = cin_out0;
        o_a1 = a_mod1; o_b1 = b_mod1; o_op1 = op_out1; o_cin1 = cin_out1;
        o_a2 = a_mod2; o_b2 = b_mod2;
        s_cnt8 = int'(op_count0);
        s_cnt2 = int'(op_count2);
        e_cnt8 = exp_cnt8;
        e_cnt2 = exp_cnt2;
        @(posedge clk);
        if (s_mxfer) begin
            void'(q.pop_front());
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        if (s_macc) q.push_back(ref_beat(ia, ib, iop, ic));
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({out_valid0, in_ready0, a_mod0, b_mod0, op_out0, cin_out0, op_count0} !==
            {1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_state: ov=%b ir=%b a=%h b=%h op=%0d cin=%b cnt=%0d, want ov=0 ir=1 rest 0",
                     out_valid0, in_ready0, a_mod0, b_mod0, op_out0, cin_out0, op_count0);
        end
        cycle(1'b1, 1'b0, 8'h11, 8'h21, 3'd0, 1'b0);
        cycle(1'b1, 1'b1, 8'h12, 8'h22, 3'd1, 1'b1);
        cycle(1'b1, 1'b0, 8'h13, 8'h23, 3'd2, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tests_run++;
        if ({s_ov0, s_ir0, s_cnt8} !== {1'b1, 1'b0, 32'sd1}) begin
            failures++;
            $display("FAIL reset_full_before: ov=%b ir=%b cnt=%0d, want ov=1 ir=0 cnt=1", s_ov0, s_ir0, s_cnt8);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid0, out_valid1, out_valid2, in_ready0, in_ready2, op_count0, op_count2} !==
            {3'b000, 2'b11, 8'h00, 2'b00}) begin
            failures++;
            $display("FAIL reset_async: ov=%b%b%b ir=%b%b cnt=%0d/%0d, want ov=000 ir=11 cnt=0/0",
                     out_valid0, out_valid1, out_valid2, in_ready0, in_ready2, op_count0, op_count2);
        end
        q.delete();
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
            tests_run++;
            if ({s_ov0, s_ov1, s_ov2, s_ir0} !== 4'b0001) begin
                failures++;
                $display("FAIL reset_no_stale: cycle %0d ov=%b%b%b ir=%b, want ov=000 ir=1",
                         i, s_ov0, s_ov1, s_ov2, s_ir0);
            end
        end
    endtask

    task automatic test_decode_cpl2_0();
        logic [7:0] tab_a [4] = '{8'h05, 8'h01, 8'h01, 8'h01};
        logic [7:0] tab_b [4] = '{8'h03, 8'h05, 8'hFA, 8'hFC};
        int seen = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            logic [2:0] iop;
            iop = 3'(i);
            cycle(i < 8, 1'b1, 8'h05, 8'h03, iop, iop[0]);
            if (s_has_exp) begin
                logic [7:0] ea, eb;
                ea = (s_exp.op < 3'd4) ? tab_a[s_exp.op[1:0]] : 8'h05;
                eb = (s_exp.op < 3'd4) ? tab_b[s_exp.op[1:0]] : 8'h03;
                seen++;
                tests_run++;
                if ({s_ov0, o_a0, o_b0, o_op0, o_cin0} !== {1'b1, ea, eb, s_exp.op, s_exp.op[0]}) begin
                    failures++;
                    $display("FAIL decode_cpl2_0 op=%0d: ov=%b a=%h b=%h op=%0d cin=%b, want ov=1 a=%h b=%h op=%0d cin=%b",
                             s_exp.op, s_ov0, o_a0, o_b0, o_op0, o_cin0, ea, eb, s_exp.op, s_exp.op[0]);
                end
            end
        end
        tests_run++;
        if (seen != 8) begin
            failures++;
            $display("FAIL decode_cpl2_0_count: beats=%0d want 8", seen);
        end
    endtask

    task automatic test_decode_cpl2_1();
        logic [7:0] in_a  [4] = '{8'h05, 8'h33, 8'h80, 8'h00};
        logic [7:0] in_b  [4] = '{8'h44, 8'h00, 8'h55, 8'h66};
        logic [2:0] in_op [4] = '{3'd2, 3'd3, 3'd2, 3'd2};
        logic [7:0] want1 [4] = '{8'hFB, 8'h00, 8'h80, 8'h00};
        logic [7:0] want0 [4] = '{8'hFA, 8'hFF, 8'h7F, 8'hFF};
        int k = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(i < 4, 1'b1, (i < 4) ? in_a[i % 4] : 8'h00, (i < 4) ? in_b[i % 4] : 8'h00,
                  (i < 4) ? in_op[i % 4] : 3'd0, 1'b1);
            if (s_has_exp && k < 4) begin
                tests_run++;
                if ({s_ov1, o_a1, o_b1, o_op1, o_cin1} !== {1'b1, 8'h00, want1[k], in_op[k], 1'b1}) begin
                    failures++;
                    $display("FAIL decode_cpl2_1 beat %0d: ov=%b a=%h b=%h op=%0d cin=%b, want ov=1 a=00 b=%h op=%0d cin=1",
                             k, s_ov1, o_a1, o_b1, o_op1, o_cin1, want1[k], in_op[k]);
                end
                tests_run++;
                if ({o_a0, o_b0} !== {8'h01, want0[k]}) begin
                    failures++;
                    $display("FAIL decode_cpl2_0_neg beat %0d: a=%h b=%h, want a=01 b=%h", k, o_a0, o_b0, want0[k]);
                end
                k++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic sent3 = 1'b0;
        int   nxt   = 1;
        do_reset();
        cycle(1'b1, 1'b0, 8'd1, 8'h00, 3'd0, 1'b0);
        cycle(1'b1, 1'b0, 8'd2, 8'h00, 3'd0, 1'b0);
        tests_run++;
        if ({s_ov0, s_ir0, o_a0} !== {1'b1, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL bp_after_beat1: ov=%b ir=%b a=%0d, want ov=1 ir=1 a=1", s_ov0, s_ir0, o_a0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'd3, 8'h00, 3'd0, 1'b0);
            tests_run++;
            if ({s_ov0, s_ir0, s_ir1, s_ir2, o_a0, o_b0} !== {1'b1, 3'b000, 8'd1, 8'h00}) begin
                failures++;
                $display("FAIL bp_stall %0d: ov=%b ir=%b%b%b a=%0d b=%0d, want ov=1 ir=000 a=1 b=0",
                         i, s_ov0, s_ir0, s_ir1, s_ir2, o_a0, o_b0);
            end
        end
        for (int i = 0; i < 12 && nxt <= 3; i++) begin
            cycle(!sent3, 1'b1, 8'd3, 8'h00, 3'd0, 1'b0);
            if (s_macc) sent3 = 1'b1;
            if (s_ov0) begin
                tests_run++;
                if (o_a0 !== 8'(nxt)) begin
                    failures++;
                    $display("FAIL bp_order: got a=%0d want %0d", o_a0, nxt);
                end
                nxt++;
            end
        end
        tests_run++;
        if (nxt != 4) begin
            failures++;
            $display("FAIL bp_drain_timeout: delivered %0d beats, want 3", nxt - 1);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] prev_a = 8'h00;
        logic [7:0] prev_b = 8'h00;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            cycle(i < 20, 1'b1, ra, rb, 3'd0, 1'b0);
            tests_run++;
            if (i > 0 && {s_ov0, s_ir0, o_a0, o_b0} !== {1'b1, 1'b1, prev_a, prev_b}) begin
                failures++;
                $display("FAIL stream cycle %0d: ov=%b ir=%b a=%h b=%h, want ov=1 ir=1 a=%h b=%h",
                         i, s_ov0, s_ir0, o_a0, o_b0, prev_a, prev_b);
            end else if (i == 0 && {s_ov0, s_ir0} !== 2'b01) begin
                failures++;
                $display("FAIL stream_first: ov=%b ir=%b, want ov=0 ir=1", s_ov0, s_ir0);
            end
            prev_a = ra;
            prev_b = rb;
        end
        cycle(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
        tests_run++;
        if ({s_ov0, s_cnt8, s_cnt2} !== {1'b0, 32'sd20, 32'sd3}) begin
            failures++;
            $display("FAIL stream_count: ov=%b cnt8=%0d cnt2=%0d, want ov=0 cnt8=20 cnt2=3", s_ov0, s_cnt8, s_cnt2);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(i < 6, 1'b1, 8'(i), 8'h00, 3'd4, 1'b0);
            tests_run++;
            if (s_cnt2 != e_cnt2 || s_cnt8 != e_cnt8) begin
                failures++;
                $display("FAIL sat_count cycle %0d: cnt2=%0d cnt8=%0d, want cnt2=%0d cnt8=%0d",
                         i, s_cnt2, s_cnt8, e_cnt2, e_cnt8);
            end
        end
        tests_run++;
        if (s_cnt2 != 3 || s_cnt8 != 6) begin
            failures++;
            $display("FAIL sat_final: cnt2=%0d cnt8=%0d, want cnt2=3 cnt8=6", s_cnt2, s_cnt8);
        end
    endtask

    task automatic test_stress();
        do_reset();
        for (int i = 0; i < 404; i++) begin
            logic v, r;
            v = (i < 400) ? 1'($urandom_range(0, 99) < 60) : 1'b0;
            r = (i < 400) ? 1'($urandom_range(0, 99) < 55) : 1'b1;
            cycle(v, r, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
            tests_run++;
            if ({s_ov0, s_ov1, s_ov2, s_ir0, s_ir1, s_ir2} !== {{3{s_occ > 0}}, {3{s_occ < 2}}}) begin
                failures++;
                $display("FAIL stress_flags cycle %0d: ov=%b%b%b ir=%b%b%b, occupancy %0d",
                         i, s_ov0, s_ov1, s_ov2, s_ir0, s_ir1, s_ir2, s_occ);
            end
            if (s_has_exp) begin
                tests_run++;
                if ({o_a0, o_b0, o_op0, o_cin0, o_a1, o_b1, o_a2, o_b2} !==
                    {s_exp.a0, s_exp.b0, s_exp.op, s_exp.cin, s_exp.a1, s_exp.b1, s_exp.a0, s_exp.b0}) begin
                    failures++;
                    $display("FAIL stress_data cycle %0d: got %h/%h op%0d c%b | %h/%h | %h/%h, want %h/%h op%0d c%b | %h/%h",
                             i, o_a0, o_b0, o_op0, o_cin0, o_a1, o_b1, o_a2, o_b2,
                             s_exp.a0, s_exp.b0, s_exp.op, s_exp.cin, s_exp.a1, s_exp.b1);
                end
            end
            tests_run++;
            if (s_cnt8 != e_cnt8 || s_cnt2 != e_cnt2) begin
                failures++;
                $display("FAIL stress_count cycle %0d: cnt8=%0d cnt2=%0d, want %0d/%0d", i, s_cnt8, s_cnt2, e_cnt8, e_cnt2);
            end
        end
        tests_run++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL stress_drain: %0d beats still expected", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_decode_cpl2_0();
        test_decode_cpl2_1();
        test_backpressure();
        test_streaming();
        test_saturation();
        test_stress();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
